// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_pkg
//  Purpose  : Shared constants and types for FND bus readback blocks:
//             active-low 7-segment glyphs ({g..a}), digit-select codes,
//             the scan-decoder state enum and a low-bit counting helper.
//  Revision : 1.0  initial release
// ============================================================================
package fnd_pkg;

  // Active-low segment glyphs, bit0=a ... bit6=g
  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  // Active-low digit selects
  localparam logic [3:0] COM_DIG0 = 4'b1110;
  localparam logic [3:0] COM_DIG1 = 4'b1101;
  localparam logic [3:0] COM_DIG2 = 4'b1011;
  localparam logic [3:0] COM_DIG3 = 4'b0111;
  localparam logic [3:0] COM_NONE = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } fnd_state_e;

  // Number of asserted (low) bits in a digit-select code
  function automatic logic [2:0] low_count(input logic [3:0] c);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~c[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_to_hex.sv
`default_nettype none
// ============================================================================
//  Module   : seg7_to_hex
//  Purpose  : Combinational inverse of the hex 7-segment table.
//  Ports    : seg    in  [6:0] active-low segments {g..a}
//             nibble out [3:0] decoded hex value (0 when no hit)
//             hit    out       1 when seg matches a hex glyph
//  Note     : blank (7'h7F) and any non-glyph pattern report hit=0.
//  Revision : 1.0  initial release
// ============================================================================
module seg7_to_hex
  import fnd_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       hit
);

  always_comb begin
    nibble = 4'h0;
    hit    = 1'b1;
    case (seg)
      SEG_0:   nibble = 4'h0;
      SEG_1:   nibble = 4'h1;
      SEG_2:   nibble = 4'h2;
      SEG_3:   nibble = 4'h3;
      SEG_4:   nibble = 4'h4;
      SEG_5:   nibble = 4'h5;
      SEG_6:   nibble = 4'h6;
      SEG_7:   nibble = 4'h7;
      SEG_8:   nibble = 4'h8;
      SEG_9:   nibble = 4'h9;
      SEG_A:   nibble = 4'hA;
      SEG_B:   nibble = 4'hB;
      SEG_C:   nibble = 4'hC;
      SEG_D:   nibble = 4'hD;
      SEG_E:   nibble = 4'hE;
      SEG_F:   nibble = 4'hF;
      default: hit    = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/fnd_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : fnd_scan_decoder
//  Purpose  : Passive receiver for a multiplexed 4-digit FND bus. Samples
//             each digit once its select has been stable for SETTLE_CYCLES,
//             decodes it, and publishes a coherent 16-bit frame once all
//             four digits have been captured.
//  Ports    : clk, reset_p (async, active-high)
//             com[3:0]   active-low digit select (1110 = digit0)
//             seg_7[7:0] active-low segments, bit7 = dp
//             value[15:0]  last complete frame {d3,d2,d1,d0}
//             frame_valid  pulse when value updates
//             seg_err      pulse on undecodable settled digit
//             com_err      pulse on entry to a multi-low select code
//             stale        level, no frame within TIMEOUT_CYCLES
//             dp_out[3:0]  per-digit decimal point state
//  Options  : `define FND_DP_CAPTURE_EN to capture decimal points into
//             dp_out; otherwise dp_out is tied low.
//  Revision : 1.0  initial release
// ============================================================================
module fnd_scan_decoder
  import fnd_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset_p,
  input  logic [3:0]  com,
  input  logic [7:0]  seg_7,
  output logic [15:0] value,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        com_err,
  output logic        stale,
  output logic [3:0]  dp_out
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

  logic [3:0]    com_q, com_prev;
  logic [7:0]    seg_q;
  fnd_state_e    state;
  logic [CW-1:0] cnt;
  logic [15:0]   shadow, shadow_nxt;
  logic [3:0]    seen, seen_nxt;
  logic [TW-1:0] tcnt;

  logic [3:0] dec_nib;
  logic       dec_hit;
  logic [2:0] n_low;
  logic       com_changed, com_valid, com_bad;
  logic [3:0] dig_sel;
  logic       capture_fire, capture_ok, frame_done;

  seg7_to_hex u_dec (
    .seg    (seg_q[6:0]),
    .nibble (dec_nib),
    .hit    (dec_hit)
  );

  assign n_low       = low_count(com_q);
  assign com_changed = (com_q != com_prev);
  assign com_valid   = (n_low == 3'd1);
  assign com_bad     = (n_low >= 3'd2);
  // A valid select is one-hot-low, so its inverse is the digit one-hot.
  assign dig_sel     = ~com_q;

  // Capture on the last settle cycle only if the select did not move on it.
  assign capture_fire = (state == ST_SETTLE) && !com_changed && (cnt == SETTLE_LAST);
  assign capture_ok   = capture_fire && dec_hit;
  assign seen_nxt     = seen | (capture_ok ? dig_sel : 4'h0);
  assign frame_done   = capture_ok && (seen_nxt == 4'hF);

  for (genvar i = 0; i < 4; i++) begin : g_digit
    assign shadow_nxt[4*i +: 4] = (capture_ok && dig_sel[i]) ? dec_nib : shadow[4*i +: 4];
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      com_q       <= COM_NONE;
      com_prev    <= COM_NONE;
      seg_q       <= 8'hFF;
      state       <= ST_IDLE;
      cnt         <= '0;
      shadow      <= '0;
      seen        <= '0;
      tcnt        <= '0;
      value       <= '0;
      frame_valid <= 1'b0;
      seg_err     <= 1'b0;
      com_err     <= 1'b0;
      stale       <= 1'b0;
    end else begin
      com_q       <= com;
      com_prev    <= com_q;
      seg_q       <= seg_7;
      frame_valid <= 1'b0;
      seg_err     <= capture_fire && !dec_hit;
      com_err     <= com_changed && com_bad;

      case (state)
        ST_IDLE: begin
          if (com_valid) begin
            state <= ST_SETTLE;
            cnt   <= '0;
          end
        end
        ST_SETTLE, ST_HOLD: begin
          if (com_changed) begin
            state <= com_valid ? ST_SETTLE : ST_IDLE;
            cnt   <= '0;
          end else if (state == ST_SETTLE) begin
            if (cnt == SETTLE_LAST) state <= ST_HOLD;
            else                    cnt   <= cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase

      shadow <= shadow_nxt;
      if (frame_done) begin
        value       <= shadow_nxt;
        frame_valid <= 1'b1;
        seen        <= '0;
        tcnt        <= '0;
        stale       <= 1'b0;
      end else begin
        seen <= seen_nxt;
        if (tcnt != TIMEOUT_MAX) begin
          tcnt  <= tcnt + 1'b1;
          stale <= (tcnt == TIMEOUT_MAX - 1'b1);
        end
      end
    end
  end

`ifdef FND_DP_CAPTURE_EN
  logic [3:0] dp_shadow, dp_shadow_nxt, dp_reg;

  // dp is active-low on the bus; store it as 1 = lit.
  assign dp_shadow_nxt = capture_ok ? ((dp_shadow & ~dig_sel) | (dig_sel & {4{~seg_q[7]}}))
                                    : dp_shadow;

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      dp_shadow <= '0;
      dp_reg    <= '0;
    end else begin
      dp_shadow <= dp_shadow_nxt;
      if (frame_done) dp_reg <= dp_shadow_nxt;
    end
  end

  assign dp_out = dp_reg;
`else
  logic unused_dp;
  assign unused_dp = seg_q[7];
  assign dp_out    = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_decoder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fnd_scan_decoder
//  Purpose  : Directed self-checking bench for fnd_scan_decoder
//             (SETTLE_CYCLES=8, TIMEOUT_CYCLES=100).
//  Revision : 1.0  initial release
// ============================================================================
module tb_fnd_scan_decoder;
  import fnd_pkg::*;

  logic        clk = 1'b0;
  logic        reset_p = 1'b1;
  logic [3:0]  com = 4'hF;
  logic [7:0]  seg_7 = 8'hFF;
  logic [15:0] value;
  logic        frame_valid, seg_err, com_err, stale;
  logic [3:0]  dp_out;

  int checks = 0;
  int errors = 0;

  // Pulse monitor (sole writer of these variables)
  int   fv_cnt = 0;
  int   se_cnt = 0;
  int   ce_cnt = 0;
  logic stale_d = 1'b0;
  logic stale_at_fv = 1'b1;
  logic stale_before_fv = 1'b0;

  fnd_scan_decoder #(
    .SETTLE_CYCLES  (8),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk         (clk),
    .reset_p     (reset_p),
    .com         (com),
    .seg_7       (seg_7),
    .value       (value),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .com_err     (com_err),
    .stale       (stale),
    .dp_out      (dp_out)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_valid === 1'b1) begin
      fv_cnt          = fv_cnt + 1;
      stale_at_fv     = stale;
      stale_before_fv = stale_d;
    end
    if (seg_err === 1'b1) se_cnt = se_cnt + 1;
    if (com_err === 1'b1) ce_cnt = ce_cnt + 1;
    stale_d = stale;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp)
    else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic dwell(input logic [3:0] c, input logic [7:0] s, input int n);
    com   = c;
    seg_7 = s;
    repeat (n) @(negedge clk);
  endtask

  // Full scan digit0..digit3, 20 cycles each, then idle the bus.
  task automatic scan(input logic [7:0] s0, input logic [7:0] s1,
                      input logic [7:0] s2, input logic [7:0] s3);
    dwell(COM_DIG0, s0, 20);
    dwell(COM_DIG1, s1, 20);
    dwell(COM_DIG2, s2, 20);
    dwell(COM_DIG3, s3, 20);
    dwell(COM_NONE, 8'hFF, 6);
    #2;
  endtask

  task automatic do_reset();
    com     = COM_NONE;
    seg_7   = 8'hFF;
    reset_p = 1'b1;
    repeat (3) @(negedge clk);
    reset_p = 1'b0;
    @(negedge clk);
  endtask

  int fv0, se0, ce0;

  initial begin
    // ---- reset state ----
    do_reset();
    #2;
    check("rst_value", 32'(value), 32'h0);
    check("rst_frame_valid", 32'(frame_valid), 32'h0);
    check("rst_seg_err", 32'(seg_err), 32'h0);
    check("rst_com_err", 32'(com_err), 32'h0);
    check("rst_stale", 32'(stale), 32'h0);
    check("rst_dp_out", 32'(dp_out), 32'h0);

    // ---- basic frame ----
    do_reset();
    fv0 = fv_cnt; se0 = se_cnt; ce0 = ce_cnt;
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    check("basic_fv_count", 32'(fv_cnt - fv0), 32'd1);
    check("basic_value", 32'(value), 32'h3210);
    check("basic_seg_err", 32'(se_cnt - se0), 32'd0);
    check("basic_com_err", 32'(ce_cnt - ce0), 32'd0);

    // ---- short dwell on digit2 gives no frame ----
    do_reset();
    fv0 = fv_cnt;
    dwell(COM_DIG0, 8'hC0, 20);
    dwell(COM_DIG1, 8'hF9, 20);
    dwell(COM_DIG2, 8'hA4, 5);
    dwell(COM_DIG3, 8'hB0, 20);
    dwell(COM_NONE, 8'hFF, 6);
    #2;
    check("short_no_frame", 32'(fv_cnt - fv0), 32'd0);
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    check("short_then_full_fv", 32'(fv_cnt - fv0), 32'd1);
    check("short_then_full_value", 32'(value), 32'h3210);

    // ---- blank digit1 -> seg_err, frame waits for a good digit1 ----
    do_reset();
    fv0 = fv_cnt; se0 = se_cnt;
    scan(8'hC0, 8'hFF, 8'hA4, 8'hB0);
    check("blank_seg_err", 32'(se_cnt - se0), 32'd1);
    check("blank_no_frame", 32'(fv_cnt - fv0), 32'd0);
    dwell(COM_DIG1, 8'h99, 20);
    dwell(COM_NONE, 8'hFF, 6);
    #2;
    check("blank_fixed_fv", 32'(fv_cnt - fv0), 32'd1);
    check("blank_fixed_value", 32'(value), 32'h3240);

    // ---- invalid com mid-frame ----
    do_reset();
    fv0 = fv_cnt; ce0 = ce_cnt;
    dwell(COM_DIG0, 8'hC0, 20);
    dwell(COM_DIG1, 8'hF9, 20);
    dwell(4'b1100, 8'h80, 10);
    dwell(COM_DIG2, 8'hA4, 20);
    dwell(COM_DIG3, 8'hB0, 20);
    dwell(COM_NONE, 8'hFF, 6);
    #2;
    check("comerr_count", 32'(ce_cnt - ce0), 32'd1);
    check("comerr_fv", 32'(fv_cnt - fv0), 32'd1);
    check("comerr_value", 32'(value), 32'h3210);

    // ---- timeout / stale ----
    do_reset();
    fv0 = fv_cnt;
    dwell(COM_NONE, 8'hFF, 110);
    #2;
    check("stale_set", 32'(stale), 32'h1);
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    check("stale_fv", 32'(fv_cnt - fv0), 32'd1);
    check("stale_before_fv", 32'(stale_before_fv), 32'h1);
    check("stale_clear_at_fv", 32'(stale_at_fv), 32'h0);

    // ---- decimal point on digit2 ----
    do_reset();
    scan(8'hC0, 8'hF9, 8'h10, 8'hB0);
    check("dp_value", 32'(value), 32'h3910);
`ifdef FND_DP_CAPTURE_EN
    check("dp_out", 32'(dp_out), 32'h4);
`else
    check("dp_out_tied", 32'(dp_out), 32'h0);
`endif

    // ---- reset mid-frame ----
    do_reset();
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    check("midrst_pre_value", 32'(value), 32'h3210);
    dwell(COM_DIG0, 8'h99, 20);
    dwell(COM_DIG1, 8'h99, 20);
    dwell(COM_DIG2, 8'h99, 20);
    reset_p = 1'b1;
    #1;
    check("midrst_value", 32'(value), 32'h0);
    check("midrst_outputs", 32'({frame_valid, seg_err, com_err, stale, dp_out}), 32'h0);
    @(negedge clk);
    reset_p = 1'b0;
    fv0 = fv_cnt;
    dwell(COM_DIG3, 8'hB0, 20);
    dwell(COM_NONE, 8'hFF, 6);
    #2;
    check("midrst_no_frame", 32'(fv_cnt - fv0), 32'd0);
    check("midrst_value_held", 32'(value), 32'h0);
    scan(8'hC0, 8'hF9, 8'hA4, 8'hB0);
    check("midrst_new_frame_fv", 32'(fv_cnt - fv0), 32'd1);
    check("midrst_new_frame_value", 32'(value), 32'h3210);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
